// File: rtl/int_arbiter_pkg.sv
// int_arbiter_pkg: cause codes, one-hot FSM encodings and cause helper for the interrupt arbiter
package int_arbiter_pkg;
   localparam logic [7:0] INT_PMP_CAUSE = 8'h80;
   localparam logic [7:0] INT_NONE      = 8'h00;
   localparam logic [3:0] ST_IDLE       = 4'b0001;
   localparam logic [3:0] ST_ISSUE      = 4'b0010;
   localparam logic [3:0] ST_SERVICE    = 4'b0100;
   localparam logic [3:0] ST_DRAIN      = 4'b1000;
   localparam logic [2:0] PMP_ID        = 3'd7;
   function automatic logic [7:0] cause_of(input logic pmp, input logic [2:0] id);
      return pmp ? INT_PMP_CAUSE : {5'd0, id} + 8'd1;
   endfunction
endpackage

// File: rtl/int_prio_sel.sv
// int_prio_sel: combinational picker, lowest index wins counted from the rotation base
module int_prio_sel
   import int_arbiter_pkg::*;
#(
   parameter int N  = 8,
   parameter bit RR = 1'b0
) (
   input  logic [N-1:0] i_req,
   input  logic [2:0]   i_rr_ptr,
   output logic [2:0]   o_grant,
   output logic         o_valid
);
   logic [2:0]   w_base;
   logic [2:0]   w_off;
   logic [3:0]   w_sum;
   logic [N-1:0] w_rot;
   assign w_base = RR ? i_rr_ptr : 3'd0;
   assign w_rot  = N'({i_req, i_req} >> w_base);
   always_comb begin
      w_off = 3'd0;
      for (int i = N - 1; i >= 0; i--) w_off = w_rot[i] ? 3'(i) : w_off;
   end
   assign w_sum   = {1'b0, w_base} + {1'b0, w_off};
   assign o_grant = (w_sum >= 4'(N)) ? 3'(w_sum - 4'(N)) : w_sum[2:0];
   assign o_valid = |i_req;
endmodule

// File: rtl/int_arbiter.sv
// int_arbiter: sticky interrupt capture, masked arbitration and issue/service handshake to the interruptor
module int_arbiter
   import int_arbiter_pkg::*;
#(
   parameter int NUM_SRC = 8,
   parameter bit RR_EN   = 1'b0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_SRC-1:0] irq_i,
   input  logic [NUM_SRC-1:0] irq_en_i,
   input  logic               global_en_i,
   input  logic               pmp_fault_i,
   input  logic               int_busy_i,
   input  logic               mret_i,
   output logic [7:0]         int_flag_o,
   output logic               int_pmp_flag_o,
   output logic [NUM_SRC-1:0] pending_o,
   output logic               active_o,
   output logic [2:0]         active_id_o
);
   logic [NUM_SRC-1:0] r_irq_q, r_pend, w_elig, w_rise, w_clr;
   logic               r_pmp_pend, r_win_pmp, w_valid, w_accept;
   logic [3:0]         r_state;
   logic [2:0]         r_win_id, r_rr_ptr, w_grant;
   assign w_rise   = irq_i & ~r_irq_q;
   assign w_elig   = r_pend & irq_en_i & {NUM_SRC{global_en_i}};
   assign w_accept = (r_state == ST_ISSUE) & int_busy_i;
   assign w_clr    = (w_accept & ~r_win_pmp) ? NUM_SRC'(1) << r_win_id : '0;
   int_prio_sel #(.N(NUM_SRC), .RR(RR_EN)) u_sel (
      .i_req    (w_elig),
      .i_rr_ptr (r_rr_ptr),
      .o_grant  (w_grant),
      .o_valid  (w_valid)
   );
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_irq_q    <= '0;
         r_pend     <= '0;
         r_pmp_pend <= 1'b0;
         r_state    <= ST_IDLE;
         r_win_pmp  <= 1'b0;
         r_win_id   <= 3'd0;
         r_rr_ptr   <= 3'd0;
      end else begin
         r_irq_q    <= irq_i;
         r_pend     <= (r_pend & ~w_clr) | w_rise;
         r_pmp_pend <= (r_pmp_pend & ~(w_accept & r_win_pmp)) | pmp_fault_i;
         case (r_state)
            ST_IDLE: if (r_pmp_pend | w_valid) begin
               r_state   <= ST_ISSUE;
               r_win_pmp <= r_pmp_pend;
               r_win_id  <= r_pmp_pend ? PMP_ID : w_grant;
            end
            ST_ISSUE: if (int_busy_i) begin
               r_state  <= ST_SERVICE;
               r_rr_ptr <= r_win_pmp ? r_rr_ptr : (r_win_id == 3'(NUM_SRC - 1)) ? 3'd0 : r_win_id + 3'd1;
            end
            ST_SERVICE: r_state <= mret_i ? ST_DRAIN : ST_SERVICE;
            default:    r_state <= ST_IDLE;
         endcase
      end
   end
   assign int_flag_o     = (r_state == ST_ISSUE) ? cause_of(r_win_pmp, r_win_id) : INT_NONE;
   assign int_pmp_flag_o = (r_state == ST_ISSUE) & r_win_pmp;
   assign active_o       = (r_state == ST_ISSUE) | (r_state == ST_SERVICE);
   assign active_id_o    = active_o ? r_win_id : 3'd0;
   assign pending_o      = r_pend;
endmodule

// File: tb/tb_int_arbiter.sv
// tb_int_arbiter: directed scenarios on a fixed-priority and a round-robin instance sharing stimulus
module tb_int_arbiter;
   logic       clk, rst, global_en_i, pmp_fault_i, int_busy_i, mret_i;
   logic [7:0] irq_i, irq_en_i;
   logic [7:0] flag, rr_flag, pending, rr_pending;
   logic       pmp_flag, rr_pmp_flag, active, rr_active;
   logic [2:0] active_id, rr_active_id;
   int         n_vec = 0;
   int         n_err = 0;

   int_arbiter #(.NUM_SRC(8), .RR_EN(1'b0)) dut (
      .clk(clk), .rst(rst), .irq_i(irq_i), .irq_en_i(irq_en_i), .global_en_i(global_en_i),
      .pmp_fault_i(pmp_fault_i), .int_busy_i(int_busy_i), .mret_i(mret_i),
      .int_flag_o(flag), .int_pmp_flag_o(pmp_flag), .pending_o(pending),
      .active_o(active), .active_id_o(active_id)
   );
   int_arbiter #(.NUM_SRC(8), .RR_EN(1'b1)) dut_rr (
      .clk(clk), .rst(rst), .irq_i(irq_i), .irq_en_i(irq_en_i), .global_en_i(global_en_i),
      .pmp_fault_i(pmp_fault_i), .int_busy_i(int_busy_i), .mret_i(mret_i),
      .int_flag_o(rr_flag), .int_pmp_flag_o(rr_pmp_flag), .pending_o(rr_pending),
      .active_o(rr_active), .active_id_o(rr_active_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      irq_i = 8'h00; irq_en_i = 8'hFF; global_en_i = 1'b1;
      pmp_fault_i = 1'b0; int_busy_i = 1'b0; mret_i = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
   endtask

   // accept, re-fire the given sources during service, mret, then drain back to idle
   task automatic serve(input logic [7:0] refire);
      int_busy_i = 1'b1;
      tick();
      int_busy_i = 1'b0;
      irq_i = irq_i & ~refire;
      mret_i = 1'b1;
      tick();
      mret_i = 1'b0;
      irq_i = irq_i | refire;
      tick();
   endtask

   task automatic test_reset();
      irq_i = 8'h00; irq_en_i = 8'hFF; global_en_i = 1'b1;
      pmp_fault_i = 1'b0; int_busy_i = 1'b0; mret_i = 1'b0;
      rst = 1'b1;
      tick();
      n_vec++; if ({flag, pmp_flag, pending, active, active_id} !== 21'd0) begin n_err++;
         $display("FAIL reset_fixed: got flag=%h pmp=%b pend=%h act=%b id=%0d want all 0", flag, pmp_flag, pending, active, active_id); end
      n_vec++; if ({rr_flag, rr_pmp_flag, rr_pending, rr_active, rr_active_id} !== 21'd0) begin n_err++;
         $display("FAIL reset_rr: got flag=%h pmp=%b pend=%h act=%b id=%0d want all 0", rr_flag, rr_pmp_flag, rr_pending, rr_active, rr_active_id); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single();
      do_reset();
      irq_i = 8'h04;
      tick();
      n_vec++; if (pending !== 8'h04) begin n_err++; $display("FAIL single_pend: got %h want 04", pending); end
      n_vec++; if (flag !== 8'h00) begin n_err++; $display("FAIL single_early: got %h want 00", flag); end
      tick();
      n_vec++; if (flag !== 8'h03) begin n_err++; $display("FAIL single_issue: got %h want 03", flag); end
      n_vec++; if (active_id !== 3'd2) begin n_err++; $display("FAIL single_id: got %0d want 2", active_id); end
      tick();
      tick();
      n_vec++; if (flag !== 8'h03) begin n_err++; $display("FAIL single_hold: got %h want 03", flag); end
      int_busy_i = 1'b1;
      tick();
      int_busy_i = 1'b0;
      n_vec++; if ({flag, pending, active} !== {8'h00, 8'h00, 1'b1}) begin n_err++;
         $display("FAIL single_service: got flag=%h pend=%h act=%b want 00 00 1", flag, pending, active); end
      tick();
      n_vec++; if (active !== 1'b1) begin n_err++; $display("FAIL single_wait_mret: got %b want 1", active); end
      mret_i = 1'b1;
      tick();
      mret_i = 1'b0;
      n_vec++; if (active !== 1'b0) begin n_err++; $display("FAIL single_drain: got %b want 0", active); end
      tick();
      tick();
      n_vec++; if ({flag, active} !== 9'd0) begin n_err++; $display("FAIL single_idle: got flag=%h act=%b want 00 0", flag, active); end
   endtask

   task automatic test_fixed();
      do_reset();
      irq_i = 8'h22;
      tick();
      tick();
      n_vec++; if (flag !== 8'h02) begin n_err++; $display("FAIL fixed_first: got %h want 02", flag); end
      serve(8'h00);
      tick();
      n_vec++; if (flag !== 8'h06) begin n_err++; $display("FAIL fixed_second: got %h want 06", flag); end
      serve(8'h00);
      n_vec++; if ({flag, pending} !== 16'h0000) begin n_err++; $display("FAIL fixed_done: got flag=%h pend=%h want 00 00", flag, pending); end
   endtask

   task automatic test_round_robin();
      do_reset();
      irq_i = 8'h03;
      tick();
      tick();
      n_vec++; if (rr_flag !== 8'h01) begin n_err++; $display("FAIL rr_grant0: got %h want 01", rr_flag); end
      serve(8'h03);
      tick();
      n_vec++; if (rr_flag !== 8'h02) begin n_err++; $display("FAIL rr_grant1: got %h want 02", rr_flag); end
      n_vec++; if (flag !== 8'h01) begin n_err++; $display("FAIL rr_fixed_ref: got %h want 01", flag); end
      serve(8'h03);
      tick();
      n_vec++; if (rr_flag !== 8'h01) begin n_err++; $display("FAIL rr_grant2: got %h want 01", rr_flag); end
   endtask

   task automatic test_mask_and_reset();
      do_reset();
      irq_en_i = 8'hF7;
      irq_i = 8'h08;
      tick();
      tick();
      tick();
      n_vec++; if ({flag, pending} !== {8'h00, 8'h08}) begin n_err++;
         $display("FAIL mask_hold: got flag=%h pend=%h want 00 08", flag, pending); end
      irq_en_i = 8'hFF;
      tick();
      n_vec++; if (flag !== 8'h04) begin n_err++; $display("FAIL mask_release: got %h want 04", flag); end
      #1;
      rst = 1'b1;
      #1;
      n_vec++; if ({flag, pmp_flag, pending, active} !== 18'd0) begin n_err++;
         $display("FAIL async_reset: got flag=%h pmp=%b pend=%h act=%b want all 0", flag, pmp_flag, pending, active); end
      rst = 1'b0;
      irq_i = 8'h00;
      tick();
   endtask

   task automatic test_pmp();
      do_reset();
      irq_i = 8'h01;
      tick();
      tick();
      n_vec++; if (flag !== 8'h01) begin n_err++; $display("FAIL pmp_src0_issue: got %h want 01", flag); end
      mret_i = 1'b1;
      tick();
      mret_i = 1'b0;
      n_vec++; if (flag !== 8'h01) begin n_err++; $display("FAIL pmp_mret_ignored: got %h want 01", flag); end
      int_busy_i = 1'b1;
      tick();
      int_busy_i = 1'b0;
      pmp_fault_i = 1'b1;
      irq_i = 8'h00;
      tick();
      pmp_fault_i = 1'b0;
      irq_i = 8'h01;
      tick();
      mret_i = 1'b1;
      tick();
      mret_i = 1'b0;
      tick();
      tick();
      n_vec++; if ({flag, pmp_flag, active_id} !== {8'h80, 1'b1, 3'd7}) begin n_err++;
         $display("FAIL pmp_first: got flag=%h pmp=%b id=%0d want 80 1 7", flag, pmp_flag, active_id); end
      serve(8'h00);
      tick();
      n_vec++; if ({flag, pmp_flag} !== {8'h01, 1'b0}) begin n_err++;
         $display("FAIL pmp_then_src0: got flag=%h pmp=%b want 01 0", flag, pmp_flag); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      irq_i = 8'h04;
      tick();
      irq_i = 8'h00;
      tick();
      n_vec++; if (flag !== 8'h03) begin n_err++; $display("FAIL b2b_issue: got %h want 03", flag); end
      pmp_fault_i = 1'b1;
      tick();
      pmp_fault_i = 1'b0;
      n_vec++; if ({flag, pmp_flag} !== {8'h03, 1'b0}) begin n_err++;
         $display("FAIL b2b_frozen: got flag=%h pmp=%b want 03 0", flag, pmp_flag); end
      irq_i = 8'h04;
      int_busy_i = 1'b1;
      tick();
      int_busy_i = 1'b0;
      n_vec++; if ({flag, pending} !== {8'h00, 8'h04}) begin n_err++;
         $display("FAIL b2b_set_wins: got flag=%h pend=%h want 00 04", flag, pending); end
      mret_i = 1'b1;
      tick();
      mret_i = 1'b0;
      tick();
      tick();
      n_vec++; if (flag !== 8'h80) begin n_err++; $display("FAIL b2b_pmp_next: got %h want 80", flag); end
      serve(8'h00);
      tick();
      n_vec++; if (flag !== 8'h03) begin n_err++; $display("FAIL b2b_reissue: got %h want 03", flag); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fixed();
      test_round_robin();
      test_mask_and_reset();
      test_pmp();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
